// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with a 256-bit line port to memory.
// Optional hit/miss counters are built when DATA_CACHE_PERF_CTR_EN is defined.
module data_cache #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         data_read,
  input  logic         data_write,
  input  logic [3:0]   data_mbe,
  input  logic [31:0]  data_addr,
  input  logic [31:0]  data_wdata,
  output logic [31:0]  data_rdata,
  output logic         data_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef DATA_CACHE_PERF_CTR_EN
  ,
  output logic [31:0]  perf_hits,
  output logic [31:0]  perf_misses
`endif
);

  localparam int TAG_W = 27 - S_INDEX;
  localparam int SETS  = 1 << S_INDEX;

  typedef enum logic [1:0] {CHECK, WRITEBACK, FILL} state_e;

  state_e             state_q;
  logic [SETS-1:0]    valid_q;
  logic [SETS-1:0]    dirty_q;
  logic [TAG_W-1:0]   tag_q  [SETS];
  logic [255:0]       line_q [SETS];

  logic [S_INDEX-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic [2:0]         word;
  logic               req;
  logic               hit;
  logic [255:0]       line_d;
  logic               unused_addr_lsbs;

  assign index            = data_addr[5 +: S_INDEX];
  assign tag              = data_addr[31 -: TAG_W];
  assign word             = data_addr[4:2];
  assign req              = data_read | data_write;
  assign hit              = valid_q[index] && (tag_q[index] == tag);
  assign unused_addr_lsbs = ^data_addr[1:0];

  // Store hit: merge enabled bytes of the selected word into the resident line.
  always_comb begin
    line_d = line_q[index];
    for (int j = 0; j < 4; j++) begin
      if (data_mbe[j]) line_d[{word, j[1:0], 3'b000} +: 8] = data_wdata[j*8 +: 8];
    end
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    data_resp    = 1'b0;
    data_rdata   = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state_q)
      CHECK: begin
        data_resp = req && hit;
        // A simultaneous read+write is a write, so no read data is returned.
        if (data_read && !data_write && hit) data_rdata = line_q[index][{word, 5'b00000} +: 32];
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[index], index, 5'b00000};
        pmem_wdata   = line_q[index];
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {data_addr[31:5], 5'b00000};
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: only valid/dirty are reset; tag and line storage stay unreset because a cleared valid bit masks them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CHECK;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      case (state_q)
        CHECK: begin
          if (req) begin
            if (hit) begin
              if (data_write) begin
                line_q[index]  <= line_d;
                dirty_q[index] <= 1'b1;
              end
            end else if (valid_q[index] && dirty_q[index]) begin
              state_q <= WRITEBACK;
            end else begin
              state_q <= FILL;
            end
          end
        end
        WRITEBACK: if (pmem_resp) state_q <= FILL;
        FILL: begin
          if (pmem_resp) begin
            line_q[index]  <= pmem_rdata;
            tag_q[index]   <= tag;
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
            state_q        <= CHECK;
          end
        end
        default: state_q <= CHECK;
      endcase
    end
  end

`ifdef DATA_CACHE_PERF_CTR_EN
  logic [31:0] perf_hits_q;
  logic [31:0] perf_misses_q;
  logic        missed_q;

  // missed_q marks a request already counted as a miss so its eventual hit response is not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_hits_q   <= '0;
      perf_misses_q <= '0;
      missed_q      <= 1'b0;
    end else if (state_q == CHECK) begin
      if (req && hit) begin
        if (!missed_q) perf_hits_q <= perf_hits_q + 32'd1;
        missed_q <= 1'b0;
      end else if (req) begin
        perf_misses_q <= perf_misses_q + 32'd1;
        missed_q      <= 1'b1;
      end else begin
        missed_q <= 1'b0;
      end
    end
  end

  assign perf_hits   = perf_hits_q;
  assign perf_misses = perf_misses_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed plan steps then random traffic against a
// transparent-memory reference (architectural line contents plus per-set residency).
module tb_data_cache;

  logic         clk = 1'b0;
  logic         rst;
  logic         data_read, data_write;
  logic [3:0]   data_mbe;
  logic [31:0]  data_addr, data_wdata;
  logic [31:0]  data_rdata;
  logic         data_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
`ifdef DATA_CACHE_PERF_CTR_EN
  logic [31:0]  perf_hits, perf_misses;
`endif

  data_cache #(.S_INDEX(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .data_read    (data_read),
    .data_write   (data_write),
    .data_mbe     (data_mbe),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .data_resp    (data_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef DATA_CACHE_PERF_CTR_EN
    ,
    .perf_hits    (perf_hits),
    .perf_misses  (perf_misses)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference: gold = architectural line contents, mem = what physical memory holds.
  logic [255:0] gold [bit [26:0]];
  logic [255:0] mem  [bit [26:0]];
  bit           m_valid [8];
  bit           m_dirty [8];
  logic [26:0]  m_line  [8];
  int           m_hits = 0;
  int           m_misses = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ensure_line(input logic [26:0] ln);
    logic [255:0] v;
    if (!gold.exists(ln)) begin
      for (int w = 0; w < 8; w++) v[w*32 +: 32] = $urandom;
      gold[ln] = v;
      mem[ln]  = v;
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) begin
      m_valid[s] = 1'b0;
      m_dirty[s] = 1'b0;
    end
    gold     = mem;
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the request completes.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] mbe, input logic [31:0] wd,
                        output logic [31:0] got);
    int          set;
    logic [26:0] ln, victim;
    bit          miss, evict;
    int          w, d;
    logic [31:0] exp_rd;
    set    = int'(addr[7:5]);
    ln     = addr[31:5];
    w      = int'(addr[4:2]);
    ensure_line(ln);
    miss   = !m_valid[set] || (m_line[set] != ln);
    evict  = miss && m_valid[set] && m_dirty[set];
    victim = m_line[set];
    data_read = rd; data_write = wr; data_addr = addr; data_mbe = mbe; data_wdata = wd;
    @(negedge clk);
    if (!miss) begin
      check("hit_same_cycle_resp", data_resp, 1);
    end else begin
      check("miss_no_resp", data_resp, 0);
      check("miss_cycle_pmem_idle", {pmem_read, pmem_write}, 2'b00);
      @(negedge clk);
      if (evict) begin
        check("wb_pmem_write", {pmem_read, pmem_write}, 2'b01);
        check("wb_address", pmem_address, {victim, 5'b00000});
        check("wb_line", pmem_wdata, gold[victim]);
        d = $urandom_range(0, 3);
        repeat (d) begin
          @(negedge clk);
          check("wb_held", {pmem_write, pmem_address}, {1'b1, victim, 5'b00000});
        end
        mem[victim] = pmem_wdata;
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
      end
      check("fill_pmem_read", {pmem_read, pmem_write}, 2'b10);
      check("fill_address", pmem_address, {ln, 5'b00000});
      d = $urandom_range(0, 3);
      repeat (d) begin
        @(negedge clk);
        check("fill_held", {pmem_read, data_resp}, 2'b10);
      end
      pmem_rdata = mem[ln];
      pmem_resp  = 1'b1;
      @(negedge clk);
      pmem_resp  = 1'b0;
      check("resp_after_fill", data_resp, 1);
      check("idle_after_fill", {pmem_read, pmem_write}, 2'b00);
    end
    exp_rd = (rd && !wr) ? gold[ln][w*32 +: 32] : 32'h0;
    check("rdata", data_rdata, exp_rd);
    got = data_rdata;
    @(posedge clk);
    #1;
    data_read = 1'b0; data_write = 1'b0;
    if (wr) begin
      for (int j = 0; j < 4; j++) if (mbe[j]) gold[ln][w*32 + j*8 +: 8] = wd[j*8 +: 8];
    end
    if (miss) begin
      m_misses++;
      m_line[set]  = ln;
      m_valid[set] = 1'b1;
      m_dirty[set] = wr;
    end else begin
      m_hits++;
      m_dirty[set] = m_dirty[set] | wr;
    end
  endtask

  initial begin
    logic [31:0]  got;
    logic [255:0] l;
    logic [23:0]  tags [4];
    tags[0] = 24'h000000; tags[1] = 24'h000001; tags[2] = 24'hABCDE5; tags[3] = 24'hFFFFFF;
    rst = 1'b1; data_read = 1'b0; data_write = 1'b0; data_mbe = '0;
    data_addr = '0; data_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_data_resp", data_resp, 0);
    check("rst_data_rdata", data_rdata, 0);
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold read of 0x40, then byte-merge store hit, then dirty eviction by 0x140.
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = 32'h1111_1111 * (i + 1);
    l[31:0]  = 32'hDEAD_BEEF;
    l[63:32] = 32'h1111_1111;
    gold[27'h2] = l;
    mem[27'h2]  = l;
    access(1, 0, 32'h0000_0040, 4'h0, 32'h0, got);
    check("plan_cold_read", got, 32'hDEAD_BEEF);
    access(0, 1, 32'h0000_0044, 4'b0100, 32'h00AA_0000, got);
    access(1, 0, 32'h0000_0044, 4'h0, 32'h0, got);
    check("plan_merged_word", got, 32'h11AA_1111);
    access(1, 0, 32'h0000_0140, 4'h0, 32'h0, got);
    check("plan_wb_stored", mem[27'h2][63:32], 32'h11AA_1111);

    // Reset while FILL waits for memory.
    ensure_line(27'h12);
    data_read = 1'b1; data_addr = 32'h0000_0240;
    @(negedge clk);
    @(negedge clk);
    check("fill_before_rst", pmem_read, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_read", {pmem_read, pmem_write}, 2'b00);
    rst = 1'b0; data_read = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Re-read misses after reset, then hit, hit, dirty miss.
    access(1, 0, 32'h0000_0140, 4'h0, 32'h0, got);
    access(0, 1, 32'h0000_0144, 4'b1111, 32'hCAFE_F00D, got);
    access(1, 0, 32'h0000_0144, 4'h0, 32'h0, got);
    check("plan_store_readback", got, 32'hCAFE_F00D);
    access(1, 0, 32'h0000_0040, 4'h0, 32'h0, got);
`ifdef DATA_CACHE_PERF_CTR_EN
    check("perf_hits_plan", perf_hits, 2);
    check("perf_misses_plan", perf_misses, 2);
`endif

    // Simultaneous read+write behaves as a write with no read data.
    access(1, 1, 32'h0000_0048, 4'b0011, 32'h0000_5A5A, got);
    access(1, 0, 32'h0000_0048, 4'h0, 32'h0, got);

    for (int i = 0; i < 400; i++) begin
      int op;
      logic [31:0] a;
      a  = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      op = $urandom_range(0, 9);
      access(op < 5 || op == 9, op >= 5, a, 4'($urandom), $urandom, got);
    end

`ifdef DATA_CACHE_PERF_CTR_EN
    check("perf_hits_final", perf_hits, m_hits);
    check("perf_misses_final", perf_misses, m_misses);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
